fpu_add_sub_align_pipe: RTL and testbench

//  Parametrised, 2-stage pipelined front end for FP add/sub. Orders operands by magnitude,

---
 rtl/fpu_add_sub_align_pipe_if.sv | 32 +++
 rtl/fpu_add_sub_align_pipe.sv | 97 +++++++++
 tb/tb_fpu_add_sub_align_pipe.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_add_sub_align_pipe_if.sv
// fpu_add_sub_align_pipe_if: operand-pair input and aligned-result output handshake bundle
interface fpu_add_sub_align_pipe_if #(
    parameter int EXPW  = 5,
    parameter int FRACW = 10
);
    localparam int DW = 1 + EXPW + FRACW;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_a;
    logic [DW-1:0]    in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [EXPW-1:0]  out_exp;
    logic [FRACW:0]   out_large_sig;
    logic [FRACW+3:0] out_small_sig;
    logic             out_large_sign;
    logic             out_small_sign;
    logic             out_eff_sub;
    logic             out_swapped;
    logic             out_special;
    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_exp, out_large_sig, out_small_sig,
               out_large_sign, out_small_sign, out_eff_sub, out_swapped, out_special
    );
    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_exp, out_large_sig, out_small_sig,
               out_large_sign, out_small_sign, out_eff_sub, out_swapped, out_special
    );
endinterface

// File: rtl/fpu_add_sub_align_pipe.sv
// fpu_add_sub_align_pipe: 2-stage FP add/sub front end (magnitude order/swap, then align with G/R/S)
module fpu_add_sub_align_pipe #(
    parameter int EXPW  = 5,
    parameter int FRACW = 10
) (
    input logic clk,
    input logic rst_n,
    fpu_add_sub_align_pipe_if.slave bus
);
    localparam int DW = 1 + EXPW + FRACW;
    localparam int EW = FRACW + 4;
    logic [EXPW-1:0]  aExp, bExp, lExp, sExp, lEff, sEff;
    logic [FRACW-1:0] lFrac, sFrac;
    logic             aSign, bSign, swap, lSign, sSign;
    logic             s1Valid, s1LargeSign, s1SmallSign, s1EffSub, s1Swapped, s1Special;
    logic [EXPW-1:0]  s1Exp, s1Diff;
    logic [FRACW:0]   s1LargeSig, s1SmallSig;
    logic [EW-1:0]    ext, sh, lostMask, aligned;
    logic             sticky, s1Adv, s2Adv;
    assign aExp  = bus.in_a[DW-2:FRACW];
    assign bExp  = bus.in_b[DW-2:FRACW];
    assign aSign = bus.in_a[DW-1];
    assign bSign = bus.in_b[DW-1] ^ bus.in_sub;
    // strict compare keeps A as the large operand on a magnitude tie
    assign swap  = bus.in_b[DW-2:0] > bus.in_a[DW-2:0];
    assign lExp  = swap ? bExp : aExp;
    assign sExp  = swap ? aExp : bExp;
    assign lFrac = swap ? bus.in_b[FRACW-1:0] : bus.in_a[FRACW-1:0];
    assign sFrac = swap ? bus.in_a[FRACW-1:0] : bus.in_b[FRACW-1:0];
    assign lSign = swap ? bSign : aSign;
    assign sSign = swap ? aSign : bSign;
    assign lEff  = (lExp == '0) ? EXPW'(1) : lExp;
    assign sEff  = (sExp == '0) ? EXPW'(1) : sExp;
    assign s2Adv = !bus.out_valid || bus.out_ready;
    assign s1Adv = !s1Valid || s2Adv;
    assign bus.in_ready = s1Adv;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1Valid     <= 1'b0;
            s1Exp       <= '0;
            s1LargeSig  <= '0;
            s1SmallSig  <= '0;
            s1LargeSign <= 1'b0;
            s1SmallSign <= 1'b0;
            s1Diff      <= '0;
            s1EffSub    <= 1'b0;
            s1Swapped   <= 1'b0;
            s1Special   <= 1'b0;
        end else if (s1Adv) begin
            s1Valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1Exp       <= lExp;
                s1LargeSig  <= {|lExp, lFrac};
                s1SmallSig  <= {|sExp, sFrac};
                s1LargeSign <= lSign;
                s1SmallSign <= sSign;
                s1Diff      <= lEff - sEff;
                s1EffSub    <= aSign ^ bSign;
                s1Swapped   <= swap;
                s1Special   <= (&aExp) | (&bExp);
            end
        end
    end
    // shifts past the G/R/S window collapse the whole significand into sticky
    assign ext      = {s1SmallSig, 3'b000};
    assign sh       = ext >> s1Diff;
    assign lostMask = ~({EW{1'b1}} << s1Diff);
    assign sticky   = sh[0] | (|(ext & lostMask));
    assign aligned  = s1Special ? '0 :
                      (int'(s1Diff) >= FRACW + 3) ? {{(EW-1){1'b0}}, |ext} :
                      {sh[EW-1:1], sticky};
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid      <= 1'b0;
            bus.out_exp        <= '0;
            bus.out_large_sig  <= '0;
            bus.out_small_sig  <= '0;
            bus.out_large_sign <= 1'b0;
            bus.out_small_sign <= 1'b0;
            bus.out_eff_sub    <= 1'b0;
            bus.out_swapped    <= 1'b0;
            bus.out_special    <= 1'b0;
        end else if (s2Adv) begin
            bus.out_valid <= s1Valid;
            if (s1Valid) begin
                bus.out_exp        <= s1Exp;
                bus.out_large_sig  <= s1LargeSig;
                bus.out_small_sig  <= aligned;
                bus.out_large_sign <= s1LargeSign;
                bus.out_small_sign <= s1SmallSign;
                bus.out_eff_sub    <= s1EffSub;
                bus.out_swapped    <= s1Swapped;
                bus.out_special    <= s1Special;
            end
        end
    end
endmodule

// File: tb/tb_fpu_add_sub_align_pipe.sv
// tb_fpu_add_sub_align_pipe: directed FP16 vectors checked against a scoreboard model and literals
module tb_fpu_add_sub_align_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    fpu_add_sub_align_pipe_if bus ();
    fpu_add_sub_align_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    typedef struct packed {
        logic [4:0]  e;
        logic [10:0] ls;
        logic [13:0] ss;
        logic        lsg, ssg, es, sw, sp;
    } res_t;
    res_t expQ[$];
    res_t cur, held, want;
    logic holdV = 1'b0;
    int nCmp = 0, nErr = 0, nOut = 0;
    localparam logic [15:0] VA [10] = '{16'h3C00, 16'h3800, 16'h4C00, 16'h7800, 16'h0001,
                                        16'hC000, 16'h7E00, 16'h0000, 16'h5555, 16'h2AAA};
    localparam logic [15:0] VB [10] = '{16'h3800, 16'h3C00, 16'h3C01, 16'h0003, 16'h0001,
                                        16'h4400, 16'h3C00, 16'h8000, 16'hD555, 16'h3AAB};
    localparam logic VS [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    function automatic res_t model(input int a, input int b, input int sub);
        res_t r;
        int am = a & 'h7FFF, bm = b & 'h7FFF;
        int as = (a >> 15) & 1, bs = ((b >> 15) & 1) ^ sub;
        int l, s, le, se, d, ext, sh, lost;
        r.sw  = bm > am;
        l     = r.sw ? bm : am;
        s     = r.sw ? am : bm;
        r.lsg = 1'(r.sw ? bs : as);
        r.ssg = 1'(r.sw ? as : bs);
        r.es  = 1'(as ^ bs);
        le    = l >> 10;
        se    = s >> 10;
        r.e   = 5'(le);
        r.ls  = 11'((l & 'h3FF) + (le != 0 ? 1024 : 0));
        ext   = ((s & 'h3FF) + (se != 0 ? 1024 : 0)) * 8;
        r.sp  = (le == 31) || (se == 31);
        d     = (le == 0 ? 1 : le) - (se == 0 ? 1 : se);
        if (r.sp) r.ss = '0;
        else if (d >= 13) r.ss = 14'(ext != 0);
        else begin
            sh   = ext >> d;
            lost = ((ext & ((1 << d) - 1)) != 0) ? 1 : 0;
            r.ss = 14'(sh | lost);
        end
        return r;
    endfunction
    task automatic fail(input string n);
        nCmp++;
        nErr++;
        $display("FAIL %s: bound expired, got no event, required one", n);
    endtask
    task automatic chk(input string n, input int act, input int exp);
        nCmp++;
        if (act != exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h required 0x%0h", n, act, exp);
        end
    endtask
    // scoreboard: pops on every output transfer, checks held data while stalled
    always @(negedge clk) begin
        if (!rst_n) begin
            expQ.delete();
            holdV = 1'b0;
        end else begin
            cur = {bus.out_exp, bus.out_large_sig, bus.out_small_sig, bus.out_large_sign,
                   bus.out_small_sign, bus.out_eff_sub, bus.out_swapped, bus.out_special};
            if (holdV) begin
                nCmp++;
                if (!bus.out_valid || cur !== held) begin
                    nErr++;
                    $display("FAIL stall_stable: got v=%b %h required v=1 %h", bus.out_valid, cur, held);
                end
            end
            holdV = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                nCmp++;
                nOut++;
                if (expQ.size() == 0) begin
                    nErr++;
                    $display("FAIL result: got unexpected %h required no output", cur);
                end else begin
                    want = expQ.pop_front();
                    if (cur !== want) begin
                        nErr++;
                        $display("FAIL result: got %h required %h", cur, want);
                    end
                end
            end else if (bus.out_valid) begin
                holdV = 1'b1;
                held = cur;
            end
            if (bus.in_valid && bus.in_ready)
                expQ.push_back(model(int'(bus.in_a), int'(bus.in_b), int'(bus.in_sub)));
        end
    end
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_b = b;
        bus.in_sub = s;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) fail("send_timeout");
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask
    task automatic dir(input string nm, input logic [15:0] a, input logic [15:0] b, input logic s,
                       input int e, input int ls, input int ss, input int lsg, input int ssg,
                       input int es, input int sw, input int sp);
        int n = 0;
        send(a, b, s);
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        if (!bus.out_valid) fail({nm, ".wait"});
        chk({nm, ".latency"}, n, 2);
        chk({nm, ".exp"}, int'(bus.out_exp), e);
        chk({nm, ".large_sig"}, int'(bus.out_large_sig), ls);
        chk({nm, ".small_sig"}, int'(bus.out_small_sig), ss);
        chk({nm, ".large_sign"}, int'(bus.out_large_sign), lsg);
        chk({nm, ".small_sign"}, int'(bus.out_small_sign), ssg);
        chk({nm, ".eff_sub"}, int'(bus.out_eff_sub), es);
        chk({nm, ".swapped"}, int'(bus.out_swapped), sw);
        chk({nm, ".special"}, int'(bus.out_special), sp);
        @(posedge clk);
        #1;
    endtask
    task automatic drain(input string nm);
        int n = 0;
        while ((expQ.size() != 0 || bus.out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".drain_left"}, expQ.size(), 0);
        @(posedge clk);
        #1;
    endtask
    initial begin
        int base, n;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_sub = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst.out_valid", int'(bus.out_valid), 0);
        chk("rst.in_ready", int'(bus.in_ready), 1);
        chk("rst.small_sig", int'(bus.out_small_sig), 0);
        chk("rst.exp", int'(bus.out_exp), 0);
        @(posedge clk);
        #1;
        dir("add_1_half", 16'h3C00, 16'h3800, 1'b0, 15, 'h400, 'h1000, 0, 0, 0, 0, 0);
        dir("sub_half_1", 16'h3800, 16'h3C00, 1'b1, 15, 'h400, 'h1000, 1, 0, 1, 1, 0);
        dir("sticky_sat", 16'h3C00, 16'h0001, 1'b0, 15, 'h400, 'h0001, 0, 0, 0, 0, 0);
        dir("denorm", 16'h0200, 16'h0100, 1'b0, 0, 'h200, 'h0800, 0, 0, 0, 0, 0);
        dir("tie", 16'h4500, 16'h4500, 1'b0, 17, 'h500, 'h2800, 0, 0, 0, 0, 0);
        dir("sticky_d4", 16'h4C00, 16'h3C01, 1'b0, 19, 'h400, 'h0201, 0, 0, 0, 0, 0);
        dir("neg_swap", 16'hC000, 16'h4400, 1'b0, 17, 'h400, 'h1000, 0, 1, 1, 1, 0);
        dir("zeros", 16'h0000, 16'h0000, 1'b1, 0, 'h000, 'h0000, 0, 1, 1, 0, 0);
        dir("special", 16'h7C00, 16'h3C00, 1'b0, 31, 'h400, 'h0000, 0, 0, 0, 0, 1);
        // backpressure: two pairs fill both stages, the third must wait
        base = nOut;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a = 16'h3C00; bus.in_b = 16'h3800; bus.in_sub = 1'b0;
        @(negedge clk);
        chk("bp.ready0", int'(bus.in_ready), 1);
        @(posedge clk);
        #1 bus.in_a = 16'h4C00; bus.in_b = 16'h3C01;
        @(negedge clk);
        chk("bp.ready1", int'(bus.in_ready), 1);
        @(posedge clk);
        #1 bus.in_a = 16'h3800; bus.in_b = 16'h3C00; bus.in_sub = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("bp.blocked", int'(bus.in_ready), 0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) fail("bp.accept");
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        drain("bp");
        chk("bp.count", nOut - base, 3);
        // stream with intermittent downstream stalls
        base = nOut;
        fork
            begin
                for (int i = 0; i < 10; i++) send(VA[i], VB[i], VS[i]);
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    @(posedge clk);
                    #1 bus.out_ready = (k % 3) != 1;
                end
                bus.out_ready = 1'b1;
            end
        join
        drain("stream");
        chk("stream.count", nOut - base, 10);
        // reset with both stages full discards everything in flight
        bus.out_ready = 1'b0;
        send(16'h3C00, 16'h3800, 1'b0);
        send(16'h4500, 16'h4500, 1'b0);
        @(negedge clk);
        chk("full.out_valid", int'(bus.out_valid), 1);
        chk("full.in_ready", int'(bus.in_ready), 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst.out_valid", int'(bus.out_valid), 0);
        chk("midrst.in_ready", int'(bus.in_ready), 1);
        chk("midrst.exp", int'(bus.out_exp), 0);
        chk("midrst.large_sig", int'(bus.out_large_sig), 0);
        chk("midrst.small_sig", int'(bus.out_small_sig), 0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("midrst.no_ghost", int'(bus.out_valid), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1);
    end
endmodule
